// File: rtl/iiitb_apb_mbridge.sv
// APB2 master bridge: valid/ready command in, SETUP/ACCESS sequence out,
// one response pulse per command with decode-error and PREADY timeout abort.
module iiitb_apb_mbridge #(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int NSLV    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [AW-1:0]      cmd_addr,
    input  logic [DW-1:0]      cmd_wdata,
    output logic               rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic [NSLV-1:0]    PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [AW-1:0]      PADDR,
    output logic [DW-1:0]      PWDATA,
    input  logic [NSLV*DW-1:0] PRDATA,
    input  logic [NSLV-1:0]    PREADY,
    input  logic [NSLV-1:0]    PSLVERR
);

    localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [NSLV-1:0] psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SELW-1:0] idx_q, idx_d;

    logic [SELW-1:0] cmd_sel;
    logic            sel_ok;
    logic [NSLV-1:0] sel_oh;
    logic [CW-1:0]   cnt_inc;
    logic            sel_ready;
    logic            sel_err;
    logic [DW-1:0]   sel_rdata;
    logic            timeout_hit;

    assign cmd_sel     = cmd_addr[AW-1 -: SELW];
    assign sel_ok      = {1'b0, cmd_sel} < (SELW + 1)'(NSLV);
    assign sel_oh      = NSLV'(1) << cmd_sel;
    assign cnt_inc     = cnt_q + CW'(1);
    assign sel_ready   = PREADY[idx_q];
    assign sel_err     = PSLVERR[idx_q];
    assign sel_rdata   = PRDATA[idx_q*DW +: DW];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO);

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    idx_d    = cmd_sel;
                    if (sel_ok) begin
                        psel_d  = sel_oh;
                        cnt_d   = '0;
                        state_d = S_SETUP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                // a slave answering on the last allowed cycle wins over timeout
                if (sel_ready || timeout_hit) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_ready ? sel_err : 1'b1;
                    if (sel_ready && !sel_err && !pwrite_q)
                        rsp_rdata_d = sel_rdata;
                end
                if (!sel_ready)
                    cnt_d = cnt_inc;
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_iiitb_apb_mbridge.sv
// Bench for iiitb_apb_mbridge: a 2-slave/timeout-4 bridge driven from a vector
// table with a response scoreboard, and a 3-slave/no-timeout bridge for corners.
module tb_iiitb_apb_mbridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       cw;
    logic [8:0] ca;
    logic [7:0] cd;

    logic        rst_a, va, ra, rva, rea, pea, pwa;
    logic [7:0]  rda, pda;
    logic [1:0]  psa, prya, perra;
    logic [8:0]  paa;
    logic [15:0] prda;

    logic        rst_b, vb, rb, rvb, reb, peb, pwb;
    logic [7:0]  rdb, pdb;
    logic [2:0]  psb, pryb, perrb;
    logic [8:0]  pab;
    logic [23:0] prdb;

    iiitb_apb_mbridge #(.AW(9), .DW(8), .NSLV(2), .TIMEOUT(4)) u_a (
        .PCLK(clk), .PRESET(rst_a),
        .cmd_valid(va), .cmd_ready(ra), .cmd_write(cw),
        .cmd_addr(ca), .cmd_wdata(cd),
        .rsp_valid(rva), .rsp_rdata(rda), .rsp_err(rea),
        .PSEL(psa), .PENABLE(pea), .PWRITE(pwa), .PADDR(paa), .PWDATA(pda),
        .PRDATA(prda), .PREADY(prya), .PSLVERR(perra)
    );

    iiitb_apb_mbridge #(.AW(9), .DW(8), .NSLV(3), .TIMEOUT(0)) u_b (
        .PCLK(clk), .PRESET(rst_b),
        .cmd_valid(vb), .cmd_ready(rb), .cmd_write(cw),
        .cmd_addr(ca), .cmd_wdata(cd),
        .rsp_valid(rvb), .rsp_rdata(rdb), .rsp_err(reb),
        .PSEL(psb), .PENABLE(peb), .PWRITE(pwb), .PADDR(pab), .PWDATA(pdb),
        .PRDATA(prdb), .PREADY(pryb), .PSLVERR(perrb)
    );

    typedef struct {
        logic       wr;
        logic [8:0] addr;
        logic [7:0] wdata;
        int         wait_n;
        logic       slverr;
        logic [7:0] prdata;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_acc;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         due;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_a && rva) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_extra: got rsp_valid=1, expected 0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_err", rea, e.err);
                chk("rsp_rdata", rda, e.rdata);
                chk("rsp_latency", cyc, e.due);
            end
        end
    end

    // Entered at a negedge with the bridge idle; leaves at the response negedge.
    task automatic run_vec(input vec_t v);
        int idx;
        int acc;
        idx = v.addr[8];
        chk("cmd_ready_idle", ra, 1);
        va = 1'b1;
        cw = v.wr;
        ca = v.addr;
        cd = v.wdata;
        prya = '0;
        perra = '0;
        prya[1-idx] = 1'b1;
        perra[1-idx] = 1'b1;
        prda = {2{~v.prdata}};
        sb.push_back('{v.exp_err, v.exp_rdata, cyc + 2 + v.exp_acc});
        @(negedge clk);
        va = 1'b0;
        cw = 1'($urandom);
        ca = 9'($urandom);
        cd = 8'($urandom);
        chk("setup_psel", psa, 2'b01 << idx);
        chk("setup_penable", pea, 0);
        chk("setup_ready", ra, 0);
        chk("setup_paddr", paa, v.addr);
        chk("setup_pwdata", pda, v.wdata);
        chk("setup_pwrite", pwa, v.wr);
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!pea) break;
            acc++;
            chk("access_psel", psa, 2'b01 << idx);
            chk("access_paddr", paa, v.addr);
            prya[idx] = (k == v.wait_n);
            perra[idx] = (k == v.wait_n) ? v.slverr : ~v.slverr;
            prda[idx*8 +: 8] = (k == v.wait_n) ? v.prdata : 8'h33;
        end
        chk("access_cycles", acc, v.exp_acc);
        chk("done_psel", psa, 0);
        chk("done_ready", ra, 1);
        chk("hold_paddr", paa, v.addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        vecs[0] = '{1'b1, 9'h0A5, 8'h3C, 0,  1'b0, 8'h00, 1'b0, 8'h00, 1};
        vecs[1] = '{1'b0, 9'h105, 8'h00, 3,  1'b0, 8'h77, 1'b0, 8'h77, 4};
        vecs[2] = '{1'b0, 9'h010, 8'h00, 99, 1'b0, 8'h55, 1'b1, 8'h00, 4};
        vecs[3] = '{1'b0, 9'h1FF, 8'h00, 0,  1'b1, 8'hFF, 1'b1, 8'h00, 1};
        vecs[4] = '{1'b1, 9'h1C3, 8'h5A, 1,  1'b1, 8'h00, 1'b1, 8'h00, 2};
        vecs[5] = '{1'b0, 9'h0FE, 8'h00, 2,  1'b0, 8'h81, 1'b0, 8'h81, 3};
        vecs[6] = '{1'b0, 9'h100, 8'h00, 3,  1'b0, 8'hC6, 1'b0, 8'hC6, 4};
        vecs[7] = '{1'b1, 9'h000, 8'hFF, 0,  1'b0, 8'hAA, 1'b0, 8'h00, 1};

        rst_a = 1'b1; rst_b = 1'b1;
        va = 1'b0; vb = 1'b0;
        cw = 1'b0; ca = '0; cd = '0;
        prda = '0; prya = '0; perra = '0;
        prdb = 24'hABCDEF; pryb = '0; perrb = 3'b111;
        repeat (2) @(negedge clk);
        chk("rst_ready", ra, 1);
        chk("rst_rsp_valid", rva, 0);
        chk("rst_rsp_err", rea, 0);
        chk("rst_rsp_rdata", rda, 0);
        chk("rst_psel", psa, 0);
        chk("rst_penable", pea, 0);
        chk("rst_pwrite", pwa, 0);
        chk("rst_paddr", paa, 0);
        chk("rst_pwdata", pda, 0);
        chk("rst_b_ready", rb, 1);
        chk("rst_b_psel", psb, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        // decode error on the 3-slave bridge: selection bits 11 -> slave 3
        vb = 1'b1; cw = 1'b0; ca = 9'h180; cd = 8'h00;
        @(negedge clk);
        vb = 1'b0;
        chk("dec_psel", psb, 0);
        chk("dec_penable", peb, 0);
        chk("dec_rsp_valid", rvb, 1);
        chk("dec_rsp_err", reb, 1);
        chk("dec_rsp_rdata", rdb, 0);
        chk("dec_ready", rb, 1);
        @(negedge clk);
        chk("dec_rsp_pulse", rvb, 0);

        // no timeout: a stalled write to slave 2 must wait indefinitely
        vb = 1'b1; cw = 1'b1; ca = 9'h100; cd = 8'hE7;
        @(negedge clk);
        vb = 1'b0;
        chk("stall_setup_psel", psb, 3'b100);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rvb) seen = 1'b1;
        end
        chk("stall_no_rsp", seen, 0);
        chk("stall_penable", peb, 1);
        chk("stall_psel", psb, 3'b100);

        // asynchronous reset in the middle of the stalled ACCESS
        #2 rst_b = 1'b1;
        #1;
        chk("arst_psel", psb, 0);
        chk("arst_penable", peb, 0);
        chk("arst_pwrite", pwb, 0);
        chk("arst_paddr", pab, 0);
        chk("arst_pwdata", pdb, 0);
        chk("arst_rsp_valid", rvb, 0);
        chk("arst_ready", rb, 1);
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_valid", rvb, 0);
        chk("post_rst_ready", rb, 1);

        pryb = 3'b010; perrb = 3'b101;
        vb = 1'b1; cw = 1'b1; ca = 9'h080; cd = 8'h5C;
        @(negedge clk);
        vb = 1'b0;
        chk("post_setup_psel", psb, 3'b010);
        chk("post_setup_penable", peb, 0);
        @(negedge clk);
        chk("post_access_penable", peb, 1);
        chk("post_access_pwdata", pdb, 8'h5C);
        chk("post_access_pwrite", pwb, 1);
        @(negedge clk);
        chk("post_rsp_valid", rvb, 1);
        chk("post_rsp_err", reb, 0);
        chk("post_rsp_rdata", rdb, 0);
        chk("post_psel", psb, 0);
        @(negedge clk);
        chk("post_rsp_pulse", rvb, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
